// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared definitions for the multiply/divide controller.
//   - md op codes carried on mdop
//   - FSM state encodings (md_idle, md_run)
//   - default busy-cycle counts for multiply and divide
//   - helper that classifies an op as a long multi-cycle operation
package md_ctrl_pkg;

   localparam logic [2:0] md_mult  = 3'd0;
   localparam logic [2:0] md_multu = 3'd1;
   localparam logic [2:0] md_div   = 3'd2;
   localparam logic [2:0] md_divu  = 3'd3;
   localparam logic [2:0] md_mthi  = 3'd4;
   localparam logic [2:0] md_mtlo  = 3'd5;

   localparam int md_mult_cycles_def = 5;
   localparam int md_div_cycles_def  = 10;

   typedef enum logic {
      md_idle = 1'b0,
      md_run  = 1'b1
   } md_state_t;

   // mult/multu/div/divu occupy codes 0-3, so bit 2 clear marks a long op.
   function automatic logic is_long_op(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational arithmetic for the multiply/divide controller.
// Ports:
//   op      in  3   md op code (only 0-3 produce a result; others give 0)
//   a       in  32  rs operand (multiplicand / dividend)
//   b       in  32  rt operand (multiplier / divisor)
//   hi      out 32  product[63:32] or remainder
//   lo      out 32  product[31:0] or quotient
//   divzero out 1   divide op with b == 0 (result must not be committed)
module md_arith
   import md_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        divzero
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] b_safe;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_u;
   logic [31:0] r_u;

   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Divisor forced to 1 on zero so the dividers never see x/0; the
   // result is discarded via divzero anyway.
   assign b_safe = (b == 32'd0) ? 32'd1 : b;

   // Signed divide done on magnitudes: avoids the 0x80000000 / -1
   // overflow case (magnitude 0x80000000 fits unsigned, negation wraps
   // back to 0x80000000 as required).
   assign a_mag = a[31]      ? (~a + 32'd1)      : a;
   assign b_mag = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
   assign q_mag = a_mag / b_mag;
   assign r_mag = a_mag % b_mag;
   assign q_u   = a / b_safe;
   assign r_u   = a % b_safe;

   always_comb begin
      hi      = 32'd0;
      lo      = 32'd0;
      divzero = 1'b0;
      case (op)
         md_mult: begin
            hi = prod_s[63:32];
            lo = prod_s[31:0];
         end
         md_multu: begin
            hi = prod_u[63:32];
            lo = prod_u[31:0];
         end
         md_div: begin
            // quotient truncates toward zero; remainder takes dividend sign
            lo      = (a[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
            hi      = a[31] ? (~r_mag + 32'd1) : r_mag;
            divzero = (b == 32'd0);
         end
         md_divu: begin
            lo      = q_u;
            hi      = r_u;
            divzero = (b == 32'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide controller owning HI/LO.
// Ports:
//   clk    in  1   system clock (rising edge)
//   reset  in  1   synchronous active-high reset
//   start  in  1   EX holds a valid HI/LO-writing instruction
//   mdop   in  3   0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,6-7 no-op
//   A      in  32  forwarded rs value
//   B      in  32  forwarded rt value
//   id_md  in  1   ID holds an HI/LO-class instruction
//   busy   out 1   long op starting this cycle or in flight
//   stall  out 1   id_md & busy
//   HI     out 32  HI register
//   LO     out 32  LO register
//
// Handshake: start is a single-cycle request with no ready signal. It is
// taken only in IDLE; a long op (0-3) is captured at that edge and busy
// stays high until HI/LO are committed. start seen during RUN is dropped;
// the upstream stall is what keeps it from happening in practice.
module md_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = md_mult_cycles_def,
   parameter int DIV_CYCLES  = md_div_cycles_def
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        id_md,
   output logic        busy,
   output logic        stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CLOG  = $clog2(MAXC + 1);
   localparam int CW    = (CLOG > 4) ? CLOG : 4;
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

   md_state_t     state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [31:0]   phi, phi_n;
   logic [31:0]   plo, plo_n;
   logic          pdz, pdz_n;
   logic [31:0]   hi_q, hi_n;
   logic [31:0]   lo_q, lo_n;

   logic [31:0]   ar_hi;
   logic [31:0]   ar_lo;
   logic          ar_dz;

   md_arith u_arith (
      .op      (mdop),
      .a       (A),
      .b       (B),
      .hi      (ar_hi),
      .lo      (ar_lo),
      .divzero (ar_dz)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= md_idle;
         cnt   <= '0;
         phi   <= 32'd0;
         plo   <= 32'd0;
         pdz   <= 1'b0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         phi   <= phi_n;
         plo   <= plo_n;
         pdz   <= pdz_n;
         hi_q  <= hi_n;
         lo_q  <= lo_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      phi_n   = phi;
      plo_n   = plo;
      pdz_n   = pdz;
      hi_n    = hi_q;
      lo_n    = lo_q;
      case (state)
         md_idle: begin
            if (start) begin
               if (is_long_op(mdop)) begin
                  phi_n   = ar_hi;
                  plo_n   = ar_lo;
                  pdz_n   = ar_dz;
                  // op codes 2/3 are the divides
                  cnt_n   = mdop[1] ? DIV_LD : MULT_LD;
                  state_n = md_run;
               end else if (mdop == md_mthi) begin
                  hi_n = A;
               end else if (mdop == md_mtlo) begin
                  lo_n = A;
               end
            end
         end
         md_run: begin
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) begin
               // divide-by-zero runs full length but leaves HI/LO alone
               if (!pdz) begin
                  hi_n = phi;
                  lo_n = plo;
               end
               state_n = md_idle;
            end
         end
         default: state_n = md_idle;
      endcase
   end

   assign busy  = ((state == md_idle) && start && is_long_op(mdop)) || (state == md_run);
   assign stall = id_md & busy;
   assign HI    = hi_q;
   assign LO    = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  mdop;
   logic [31:0] A;
   logic [31:0] B;
   logic        id_md;
   logic        busy;
   logic        stall;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mdop  (mdop),
      .A     (A),
      .B     (B),
      .id_md (id_md),
      .busy  (busy),
      .stall (stall),
      .HI    (HI),
      .LO    (LO)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Reference model: architectural effect of one op on HI/LO, in 64-bit
   // arithmetic, plus how many cycles busy must stay up after the start edge.
   function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] nh, output logic [31:0] nl,
                                  output int cyc, output logic commit);
      int                 ia, ib;
      logic signed [63:0] sa, sb, sp, sq, sr;
      logic [63:0]        ua, ub, up, uq, ur;
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      ua = {32'd0, a};
      ub = {32'd0, b};
      nh = exp_hi;
      nl = exp_lo;
      cyc = 0;
      commit = 1'b0;
      case (op)
         3'd0: begin
            sp = sa * sb;
            nh = sp[63:32]; nl = sp[31:0]; cyc = MC; commit = 1'b1;
         end
         3'd1: begin
            up = ua * ub;
            nh = up[63:32]; nl = up[31:0]; cyc = MC; commit = 1'b1;
         end
         3'd2: begin
            cyc = DC;
            if (b != 32'd0) begin
               sq = sa / sb;
               sr = sa % sb;
               nl = sq[31:0]; nh = sr[31:0]; commit = 1'b1;
            end
         end
         3'd3: begin
            cyc = DC;
            if (b != 32'd0) begin
               uq = ua / ub;
               ur = ua % ub;
               nl = uq[31:0]; nh = ur[31:0]; commit = 1'b1;
            end
         end
         3'd4: begin nh = a; commit = 1'b1; end
         3'd5: begin nl = a; commit = 1'b1; end
         default: ;
      endcase
   endfunction

   // Driver: issue one op and check busy/stall/HI/LO every cycle until done.
   // inject: fire a stray start during RUN that must be ignored.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic id, input logic inject);
      logic [31:0] nh, nl;
      int          cyc;
      logic        commit;
      ref_op(op, a, b, nh, nl, cyc, commit);
      start = 1'b1; mdop = op; A = a; B = b; id_md = id;
      #1;
      chkb("busy_start", busy, cyc > 0);
      chkb("stall_start", stall, id && (cyc > 0));
      tick();
      start = 1'b0;
      A = $urandom;
      B = $urandom;
      for (int k = 1; k <= cyc; k++) begin
         chkb("busy_run", busy, 1'b1);
         chkb("stall_run", stall, id);
         chk32("hi_run", HI, exp_hi);
         chk32("lo_run", LO, exp_lo);
         if (inject && k == 2) begin
            start = 1'b1;
            mdop = 3'($urandom_range(0, 5));
            A = $urandom;
            B = $urandom;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      if (commit) begin
         exp_hi = nh;
         exp_lo = nl;
      end
      #1;
      chkb("busy_done", busy, 1'b0);
      chkb("stall_done", stall, 1'b0);
      chk32("hi_done", HI, exp_hi);
      chk32("lo_done", LO, exp_lo);
   endtask

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_a, r_b;
      reset = 1'b1; start = 1'b0; mdop = 3'd0; A = 32'd0; B = 32'd0; id_md = 1'b1;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      repeat (2) tick();
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_stall", stall, 1'b0);
      chk32("rst_hi", HI, 32'd0);
      chk32("rst_lo", LO, 32'd0);
      reset = 1'b0;

      // directed sequence, back-to-back with no idle gap
      run_op(3'd0, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
      chk32("mult_hi", HI, 32'hFFFFFFFF);
      chk32("mult_lo", LO, 32'hFFFFFFFE);
      run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
      chk32("multu_hi", HI, 32'h00000001);
      chk32("multu_lo", LO, 32'hFFFFFFFE);
      run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
      chk32("div_hi", HI, 32'hFFFFFFFF);
      chk32("div_lo", LO, 32'hFFFFFFFD);
      run_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
      chk32("divu_hi", HI, 32'd1);
      chk32("divu_lo", LO, 32'd3);
      run_op(3'd4, 32'h11, 32'd0, 1'b1, 1'b0);
      run_op(3'd5, 32'h22, 32'd0, 1'b1, 1'b0);
      run_op(3'd3, 32'd7, 32'd0, 1'b1, 1'b0);
      chk32("dz_hi", HI, 32'h11);
      chk32("dz_lo", LO, 32'h22);
      run_op(3'd0, 32'd1234, 32'hFFFFFF00, 1'b1, 1'b1);
      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
      chk32("ovf_hi", HI, 32'd0);
      chk32("ovf_lo", LO, 32'h80000000);
      run_op(3'd4, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
      chk32("mthi_hi", HI, 32'hDEADBEEF);
      run_op(3'd5, 32'd5, 32'd0, 1'b0, 1'b0);
      chk32("mtlo_lo", LO, 32'd5);
      run_op(3'd6, 32'hAAAA5555, 32'd3, 1'b1, 1'b0);
      run_op(3'd7, 32'h5555AAAA, 32'd3, 1'b1, 1'b0);

      // reset during cycle 3 of a divide
      start = 1'b1; mdop = 3'd2; A = 32'd100; B = 32'd7; id_md = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      #1;
      chkb("abort_busy", busy, 1'b0);
      chk32("abort_hi", HI, 32'd0);
      chk32("abort_lo", LO, 32'd0);
      for (int k = 0; k < DC + 2; k++) begin
         tick();
         chkb("abort_busy_late", busy, 1'b0);
         chk32("abort_hi_late", HI, 32'd0);
         chk32("abort_lo_late", LO, 32'd0);
      end

      // randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
         run_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
